// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the MIPS32 inter-stage pipeline registers:
// occupancy-state encoding and per-stage payload widths.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam int unsigned IF_ID_W  = 64;
  localparam int unsigned ID_EX_W  = 128;
  localparam int unsigned EX_MEM_W = 104;
  localparam int unsigned MEM_WB_W = 72;

  // Entry count reported on occupancy is the state code itself.
  function automatic logic [1:0] occ_of(state_e s);
    return s;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle between two pipeline stages, seen from the
// register (slave) and from the surrounding stages (master).
interface pipe_stage_reg_if #(
  parameter int unsigned DW = 64
) ();

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

endinterface

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, flush
// and an optional 2-entry skid buffer that registers back-pressure.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned   DW        = 64,
  parameter logic [DW-1:0] RESET_VAL = '0,
  parameter bit            SKID      = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  pipe_stage_reg_if.slave  bus
);

  if (SKID) begin : g_skid
    state_e        state_q, state_d;
    logic [DW-1:0] main_q, main_d;
    logic [DW-1:0] skid_q, skid_d;
    logic          rdy_q;
    logic          acc, pop;

    assign acc = bus.in_valid & rdy_q;
    assign pop = bus.out_ready & (state_q != ST_EMPTY);

    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
        state_d = ST_EMPTY;
        main_d  = RESET_VAL;
        skid_d  = RESET_VAL;
      end else begin
        unique case (state_q)
          ST_EMPTY: if (acc) begin
            main_d  = bus.in_data;
            state_d = ST_ONE;
          end
          ST_ONE: begin
            if (acc && pop) begin
              main_d = bus.in_data;
            end else if (acc) begin
              skid_d  = bus.in_data;
              state_d = ST_TWO;
            end else if (pop) begin
              state_d = ST_EMPTY;
            end
          end
          ST_TWO: if (pop) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
          default: state_d = ST_EMPTY;
        endcase
      end
    end

    // in_ready is derived from the next state so it is a pure register output.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= ST_EMPTY;
        main_q  <= RESET_VAL;
        skid_q  <= RESET_VAL;
        rdy_q   <= 1'b1;
      end else begin
        state_q <= state_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
        rdy_q   <= (state_d != ST_TWO);
      end
    end

    assign bus.in_ready  = rdy_q;
    assign bus.out_valid = (state_q != ST_EMPTY);
    assign bus.out_data  = main_q;
    assign bus.occupancy = occ_of(state_q);

  end else begin : g_single
    logic          valid_q, valid_d;
    logic [DW-1:0] main_q, main_d;
    logic          rdy, acc;

    assign rdy = bus.out_ready | ~valid_q;
    assign acc = bus.in_valid & rdy;

    always_comb begin
      valid_d = valid_q;
      main_d  = main_q;
      if (flush) begin
        valid_d = 1'b0;
        main_d  = RESET_VAL;
      end else if (acc) begin
        valid_d = 1'b1;
        main_d  = bus.in_data;
      end else if (bus.out_ready) begin
        valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        valid_q <= 1'b0;
        main_q  <= RESET_VAL;
      end else begin
        valid_q <= valid_d;
        main_q  <= main_d;
      end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = main_q;
    assign bus.occupancy = {1'b0, valid_q};
  end

endmodule
